hazard_forward_ctrl: RTL and testbench

//  Control end of the operand-forwarding path: drives the 3-bit select codes consumed by the
//  D/E/M-stage forwarding muxes, and the pipeline stall. Tracks each in-flight instruction's

---
 rtl/hazard_pkg.sv | 51 +++++
 rtl/hz_stage_reg.sv | 27 ++
 rtl/hazard_forward_ctrl.sv | 62 ++++++
 tb/tb_hazard_forward_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared forwarding-select codes, Tnew/Tuse constants and the per-stage hazard record.
// Helpers here are pure combinational predicates used by the hazard controller.
package hazard_pkg;

  localparam int GPR_AW = 5;
  localparam int TFLD_W = 2;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_E    = 3'd1,
    SEL_M    = 3'd2,
    SEL_W    = 3'd3
  } sel_e;

  localparam logic [TFLD_W-1:0] TNEW_PC8  = 2'd0;
  localparam logic [TFLD_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TFLD_W-1:0] TNEW_LOAD = 2'd2;
  localparam logic [TFLD_W-1:0] TUSE_D    = 2'd0;
  localparam logic [TFLD_W-1:0] TUSE_E    = 2'd1;
  localparam logic [TFLD_W-1:0] TUSE_M    = 2'd2;

  typedef struct packed {
    logic [GPR_AW-1:0] a3;
    logic [TFLD_W-1:0] tnew;
    logic [GPR_AW-1:0] rs;
    logic [GPR_AW-1:0] rt;
    logic              rs_use;
    logic              rt_use;
  } stage_t;

  // $0 is hard-wired, so it never counts as a producer.
  function automatic logic hit(input logic [GPR_AW-1:0] a3, input logic [GPR_AW-1:0] r);
    return (r != '0) && (a3 == r);
  endfunction

  function automatic logic [2:0] prio_sel(
    input logic              use_r,
    input logic [GPR_AW-1:0] r,
    input logic [GPR_AW-1:0] a_e,
    input logic [GPR_AW-1:0] a_m,
    input logic [GPR_AW-1:0] a_w,
    input logic              en_e
  );
    if (!use_r)                return SEL_NONE;
    if (en_e && hit(a_e, r))   return SEL_E;
    if (hit(a_m, r))           return SEL_M;
    if (hit(a_w, r))           return SEL_W;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One pipeline-stage hazard record: loads a record or a bubble every cycle, optional
// saturating Tnew decrement on the way in; never holds, async clear.
module hz_stage_reg
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   dec,
  input  stage_t d,
  output stage_t q
);

  stage_t nxt;

  always_comb begin
    nxt = d;
    if (dec && (d.tnew != '0)) nxt.tnew = d.tnew - 1'b1;
    if (!load) nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= nxt;
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding-mux selects and pipeline stall from D-stage fields and E/M/W hazard records.
// Zero latency: all outputs are combinational; stall bubbles E and self-clears as Tnew drains.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = GPR_AW,
  parameter int T_W    = TFLD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_rs_use,
  input  logic              d_rt_use,
  input  logic [T_W-1:0]    d_rs_tuse,
  input  logic [T_W-1:0]    d_rt_tuse,
  input  logic [REG_AW-1:0] d_a3,
  input  logic [T_W-1:0]    d_tnew,
  output logic              stall,
  output logic [2:0]        fwd_d_rs,
  output logic [2:0]        fwd_d_rt,
  output logic [2:0]        fwd_e_rs,
  output logic [2:0]        fwd_e_rt,
  output logic [2:0]        fwd_m_rt
);

  stage_t d_rec;
  stage_t e_q;
  stage_t m_q;
  stage_t w_q;
  logic   e_load;
  logic   unused_w;

  assign d_rec = '{a3: d_a3, tnew: d_tnew, rs: d_rs, rt: d_rt,
                   rs_use: d_rs_use, rt_use: d_rt_use};
  assign e_load = d_valid && !stall;

  hz_stage_reg u_e (.clk(clk), .reset(reset), .load(e_load), .dec(1'b0), .d(d_rec), .q(e_q));
  hz_stage_reg u_m (.clk(clk), .reset(reset), .load(1'b1),   .dec(1'b1), .d(e_q),   .q(m_q));
  hz_stage_reg u_w (.clk(clk), .reset(reset), .load(1'b1),   .dec(1'b0), .d(m_q),   .q(w_q));

  // W only ever supplies its destination; the rest of the record is carried for uniformity.
  assign unused_w = ^{w_q.tnew, w_q.rs, w_q.rt, w_q.rs_use, w_q.rt_use};

  // The nearest producer wins even if it is not ready yet; stall covers that case.
  assign fwd_d_rs = prio_sel(d_rs_use, d_rs, e_q.a3, m_q.a3, w_q.a3, 1'b1);
  assign fwd_d_rt = prio_sel(d_rt_use, d_rt, e_q.a3, m_q.a3, w_q.a3, 1'b1);
  assign fwd_e_rs = prio_sel(e_q.rs_use, e_q.rs, '0, m_q.a3, w_q.a3, 1'b0);
  assign fwd_e_rt = prio_sel(e_q.rt_use, e_q.rt, '0, m_q.a3, w_q.a3, 1'b0);
  assign fwd_m_rt = prio_sel(m_q.rt_use, m_q.rt, '0, '0, w_q.a3, 1'b0);

  always_comb begin
    stall = 1'b0;
    if (d_rs_use && hit(e_q.a3, d_rs) && (e_q.tnew > d_rs_tuse)) stall = 1'b1;
    if (d_rs_use && hit(m_q.a3, d_rs) && (m_q.tnew > d_rs_tuse)) stall = 1'b1;
    if (d_rt_use && hit(e_q.a3, d_rt) && (e_q.tnew > d_rt_tuse)) stall = 1'b1;
    if (d_rt_use && hit(m_q.a3, d_rt) && (m_q.tnew > d_rt_tuse)) stall = 1'b1;
    if (!d_valid) stall = 1'b0;
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed vector table, reset-in-stall sequence, random vs model.
module tb_hazard_forward_ctrl;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_a3;
  logic       d_rs_use, d_rt_use;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       stall;
  logic [2:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

  int total = 0;
  int bad   = 0;

  hazard_forward_ctrl #(.REG_AW(5), .T_W(2)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_use(d_rs_use), .d_rt_use(d_rt_use), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_a3(d_a3), .d_tnew(d_tnew), .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, a3;
    logic       rsu, rtu;
    logic [1:0] rstu, rttu, tn;
    logic       st;
    logic [2:0] fdrs, fdrt, fers, fert, fmrt;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl [NV];

  // In-flight instruction as seen by the reference model: original Tnew, aged by stage index.
  typedef struct {
    int a3, tnew, rs, rt;
    bit rsu, rtu;
  } inst_t;
  inst_t pipe [3];

  function automatic vec_t mk(input int v, input int rs, input int rt, input int rsu, input int rtu,
                              input int rstu, input int rttu, input int a3, input int tn,
                              input int st, input int fdrs, input int fdrt, input int fers,
                              input int fert, input int fmrt);
    vec_t r;
    r.v = v[0]; r.rs = rs[4:0]; r.rt = rt[4:0]; r.rsu = rsu[0]; r.rtu = rtu[0];
    r.rstu = rstu[1:0]; r.rttu = rttu[1:0]; r.a3 = a3[4:0]; r.tn = tn[1:0];
    r.st = st[0]; r.fdrs = fdrs[2:0]; r.fdrt = fdrt[2:0];
    r.fers = fers[2:0]; r.fert = fert[2:0]; r.fmrt = fmrt[2:0];
    return r;
  endfunction

  function automatic vec_t bub(input int fers, input int fert, input int fmrt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fers, fert, fmrt);
  endfunction

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    d_valid = v.v; d_rs = v.rs; d_rt = v.rt; d_rs_use = v.rsu; d_rt_use = v.rtu;
    d_rs_tuse = v.rstu; d_rt_tuse = v.rttu; d_a3 = v.a3; d_tnew = v.tn;
  endtask

  task automatic chk_all(input string tag, input int st, input int a, input int b,
                         input int c, input int d, input int e);
    chk({tag, ".stall"}, {2'b0, stall}, st[2:0]);
    chk({tag, ".fwd_d_rs"}, fwd_d_rs, a[2:0]);
    chk({tag, ".fwd_d_rt"}, fwd_d_rt, b[2:0]);
    chk({tag, ".fwd_e_rs"}, fwd_e_rs, c[2:0]);
    chk({tag, ".fwd_e_rt"}, fwd_e_rt, d[2:0]);
    chk({tag, ".fwd_m_rt"}, fwd_m_rt, e[2:0]);
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '{a3: 0, tnew: 0, rs: 0, rt: 0, rsu: 0, rtu: 0};
  endfunction

  function automatic int remaining(input int k);
    int t;
    t = pipe[k].tnew - k;
    return (t < 0) ? 0 : t;
  endfunction

  // Search stages from `first` outward; the closest writer of r supplies the value.
  function automatic int m_sel(input bit u, input int r, input int first);
    if (!u || r == 0) return 0;
    for (int k = first; k < 3; k++)
      if (pipe[k].a3 == r) return k + 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 0;
    if (!d_valid) return 0;
    for (int k = 0; k < 2; k++) begin
      if (pipe[k].a3 != 0) begin
        if (d_rs_use && int'(d_rs) == pipe[k].a3 && remaining(k) > int'(d_rs_tuse)) s = 1;
        if (d_rt_use && int'(d_rt) == pipe[k].a3 && remaining(k) > int'(d_rt_tuse)) s = 1;
      end
    end
    return s;
  endfunction

  function automatic void model_step(input bit st);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (d_valid && !st)
      pipe[0] = '{a3: int'(d_a3), tnew: int'(d_tnew), rs: int'(d_rs), rt: int'(d_rt),
                  rsu: d_rs_use, rtu: d_rt_use};
    else
      pipe[0] = '{a3: 0, tnew: 0, rs: 0, rt: 0, rsu: 0, rtu: 0};
  endfunction

  initial begin
    bit exp_st;
    int e_drs, e_drt, e_ers, e_ert, e_mrt;

    //           v  rs rt ru tu rsT rtT a3 tn | st fdrs fdrt fers fert fmrt
    tbl[0]  = mk(1, 1, 2, 1, 1, 1, 1, 3, 1,  0, 0, 0, 0, 0, 0);   // addu $3
    tbl[1]  = mk(1, 3, 2, 1, 1, 1, 1, 4, 1,  0, 1, 0, 0, 0, 0);   // addu $4,$3
    tbl[2]  = bub(2, 0, 0);
    tbl[3]  = bub(0, 0, 0);
    tbl[4]  = bub(0, 0, 0);
    tbl[5]  = mk(1, 29, 5, 1, 0, 1, 0, 5, 2, 0, 0, 0, 0, 0, 0);   // lw $5
    tbl[6]  = mk(1, 5, 1, 1, 1, 1, 1, 6, 1,  1, 1, 0, 0, 0, 0);   // addu $6,$5 stalls
    tbl[7]  = mk(1, 5, 1, 1, 1, 1, 1, 6, 1,  0, 2, 0, 0, 0, 0);
    tbl[8]  = bub(3, 0, 0);
    tbl[9]  = bub(0, 0, 0);
    tbl[10] = bub(0, 0, 0);
    tbl[11] = mk(1, 29, 5, 1, 0, 1, 0, 5, 2, 0, 0, 0, 0, 0, 0);   // lw $5
    tbl[12] = mk(1, 5, 0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);   // beq $5,$0
    tbl[13] = mk(1, 5, 0, 1, 1, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0);
    tbl[14] = mk(1, 5, 0, 1, 1, 0, 0, 0, 0,  0, 3, 0, 0, 0, 0);
    tbl[15] = bub(0, 0, 0);
    tbl[16] = bub(0, 0, 0);
    tbl[17] = bub(0, 0, 0);
    tbl[18] = mk(1, 29, 0, 1, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0);   // lw $0
    tbl[19] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);   // beq $0,$0
    tbl[20] = bub(0, 0, 0);
    tbl[21] = bub(0, 0, 0);
    tbl[22] = bub(0, 0, 0);
    tbl[23] = mk(1, 1, 2, 1, 1, 1, 1, 7, 1,  0, 0, 0, 0, 0, 0);   // addu $7
    tbl[24] = mk(1, 29, 7, 1, 1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);   // sw $7
    tbl[25] = bub(0, 2, 0);
    tbl[26] = bub(0, 0, 3);
    tbl[27] = bub(0, 0, 0);
    tbl[28] = mk(1, 1, 2, 1, 1, 1, 1, 8, 1,  0, 0, 0, 0, 0, 0);   // addu $8
    tbl[29] = mk(1, 1, 2, 1, 1, 1, 1, 8, 1,  0, 0, 0, 0, 0, 0);   // addu $8 again
    tbl[30] = mk(1, 8, 8, 1, 0, 1, 0, 9, 1,  0, 1, 0, 0, 0, 0);   // reader, rt unused
    tbl[31] = bub(2, 0, 0);
    tbl[32] = bub(0, 0, 0);
    tbl[33] = bub(0, 0, 0);

    reset = 1'b1;
    apply(bub(0, 0, 0));
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i]);
      #2;
      chk_all($sformatf("vec%0d", i), int'(tbl[i].st), int'(tbl[i].fdrs), int'(tbl[i].fdrt),
              int'(tbl[i].fers), int'(tbl[i].fert), int'(tbl[i].fmrt));
      @(posedge clk); #1;
    end

    // Reset lands while a load in E is stalling the reader in D.
    apply(tbl[5]);
    @(posedge clk); #1;
    apply(tbl[6]);
    #2;
    chk("rst_pre.stall", {2'b0, stall}, 3'd1);
    chk("rst_pre.fwd_d_rs", fwd_d_rs, 3'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid.stall", {2'b0, stall}, 3'd0);
    chk("rst_mid.fwd_d_rs", fwd_d_rs, 3'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk_all("rst_post0", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    apply(mk(0, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk_all("rst_post1", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    apply(mk(1, 1, 2, 1, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    apply(mk(1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("rst_reload.fwd_d_rs", fwd_d_rs, 3'd1);
    @(posedge clk); #1;

    // Randomized traffic against the reference model, with occasional async reset pulses.
    reset = 1'b1;
    model_clear();
    #1;
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_clear();
      end
      d_valid   = ($urandom_range(0, 3) != 0);
      d_rs      = 5'($urandom_range(0, 3));
      d_rt      = 5'($urandom_range(0, 3));
      d_rs_use  = 1'($urandom_range(0, 1));
      d_rt_use  = 1'($urandom_range(0, 1));
      d_rs_tuse = 2'($urandom_range(0, 2));
      d_rt_tuse = 2'($urandom_range(0, 2));
      d_a3      = 5'($urandom_range(0, 3));
      d_tnew    = 2'($urandom_range(0, 2));
      #1;
      exp_st = m_stall();
      e_drs  = m_sel(d_rs_use, int'(d_rs), 0);
      e_drt  = m_sel(d_rt_use, int'(d_rt), 0);
      e_ers  = m_sel(pipe[0].rsu, pipe[0].rs, 1);
      e_ert  = m_sel(pipe[0].rtu, pipe[0].rt, 1);
      e_mrt  = m_sel(pipe[1].rtu, pipe[1].rt, 2);
      chk_all($sformatf("rnd%0d", n), int'(exp_st), e_drs, e_drt, e_ers, e_ert, e_mrt);
      @(posedge clk);
      model_step(exp_st);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
